// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the PC, keeps one imem read in flight, presents to decode via valid/ready.
// Build option FETCH_PERF_EN adds the perf_fetched / perf_redirects counters.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_redirects
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FETCH   = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;
    localparam logic [1:0] HOLD    = 2'd3;

    logic [1:0]  state;
    logic [31:0] pc_q;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc_q      <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            if_valid  <= 1'b0;
            if_pc     <= '0;
            if_instr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state     <= FETCH;
                    imem_req  <= 1'b1;
                    imem_addr <= pc_q;
                end
                FETCH: begin
                    if (imem_ack && !redirect_valid) begin
                        if_instr <= imem_rdata;
                        if_pc    <= pc_q;
                        if_valid <= 1'b1;
                        pc_q     <= pc_q + 32'd4;
                        imem_req <= 1'b0;
                        state    <= HOLD;
                    end else if (imem_ack) begin
                        // Response completes together with the redirect: reissue at the target.
                        pc_q      <= redirect_tgt;
                        imem_addr <= redirect_tgt;
                    end else if (redirect_valid) begin
                        pc_q  <= redirect_tgt;
                        state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (redirect_valid)
                        pc_q <= redirect_tgt;
                    if (imem_ack) begin
                        imem_addr <= redirect_valid ? redirect_tgt : pc_q;
                        state     <= FETCH;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        if_valid  <= 1'b0;
                        pc_q      <= redirect_tgt;
                        imem_req  <= 1'b1;
                        imem_addr <= redirect_tgt;
                        state     <= FETCH;
                    end else if (if_ready) begin
                        if_valid  <= 1'b0;
                        imem_req  <= 1'b1;
                        imem_addr <= pc_q;
                        state     <= FETCH;
                    end
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched   <= '0;
            perf_redirects <= '0;
        end else begin
            if (state == HOLD && if_ready && !redirect_valid)
                perf_fetched <= perf_fetched + 32'd1;
            if (state != IDLE && redirect_valid)
                perf_redirects <= perf_redirects + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then random traffic, checked each cycle
// against a transaction-level model of the fetch stream and a latency-randomised memory.
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready = 1'b0;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_redirects;
`endif

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_ready       (if_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_redirects (perf_redirects)
`endif
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: the expected fetch stream, described as "is a read outstanding,
    // is its data already doomed, what is presented, where does fetching continue".
    bit          model_known = 0;
    bit          m_started, m_req, m_doomed, m_valid;
    logic [31:0] m_next, m_addr, m_pc, m_instr, m_fetched, m_redirects;

    // Memory model: one request at a time, ack after a random latency.
    bit          mem_busy = 0;
    int unsigned mem_age, mem_lat;
    int unsigned lat_min = 1, lat_max = 1, stray_pct = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        check("req", {31'd0, imem_req}, {31'd0, m_req});
        if (m_req || !m_started)
            check("addr", imem_addr, m_addr);
        check("valid", {31'd0, if_valid}, {31'd0, m_valid});
        if (m_valid || !m_started) begin
            check("if_pc", if_pc, m_pc);
            check("if_instr", if_instr, m_instr);
        end
`ifdef FETCH_PERF_EN
        check("perf_fetched", perf_fetched, m_fetched);
        check("perf_redirects", perf_redirects, m_redirects);
`endif
    endtask

    // Called at a negedge: check the current cycle, drive its inputs, advance to next negedge.
    task automatic step(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy, input bit stray);
        bit          ack;
        logic [31:0] tgt;
        logic [31:0] data;
        if (model_known)
            compare_outputs();
        ack = 1'b0;
        if (rst) begin
            mem_busy = 0;
        end else begin
            if (imem_req && !mem_busy) begin
                mem_busy = 1;
                mem_age  = 0;
                mem_lat  = $urandom_range(lat_max, lat_min);
            end else if (mem_busy) begin
                mem_age++;
            end
            if (mem_busy && mem_age >= mem_lat) begin
                ack      = 1'b1;
                mem_busy = 0;
            end else if (!mem_busy && !imem_req && (stray || $urandom_range(99, 0) < stray_pct)) begin
                ack = 1'b1;
            end
        end
        data           = $urandom;
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
        imem_ack       = ack;
        imem_rdata     = data;

        tgt = rpc & 32'hFFFF_FFFC;
        if (rst) begin
            model_known = 1;
            m_started = 0; m_req = 0; m_doomed = 0; m_valid = 0;
            m_next = RST_PC; m_addr = RST_PC; m_pc = '0; m_instr = '0;
            m_fetched = '0; m_redirects = '0;
        end else begin
            if (m_started && rv)
                m_redirects = m_redirects + 1;
            if (!m_started) begin
                m_started = 1;
                m_req     = 1;
                m_addr    = m_next;
            end else if (m_req) begin
                if (ack) begin
                    if (!m_doomed && !rv) begin
                        m_valid = 1; m_pc = m_addr; m_instr = data;
                        m_next  = m_addr + 32'd4;
                        m_req   = 0;
                    end else begin
                        if (rv) m_next = tgt;
                        m_addr   = m_next;
                        m_doomed = 0;
                    end
                end else if (rv) begin
                    m_next   = tgt;
                    m_doomed = 1;
                end
            end else begin
                if (rv) begin
                    m_valid = 0; m_next = tgt; m_req = 1; m_addr = tgt;
                end else if (rdy) begin
                    m_valid = 0; m_fetched = m_fetched + 1; m_req = 1; m_addr = m_next;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [31:0] held_instr;

    initial begin
        @(negedge clk);

        // 1: back-to-back fetch at 1-cycle latency, decode always ready
        repeat (3) step(1, 0, '0, 1, 0);
        check("t1_rst_req", {31'd0, imem_req}, 32'd0);
        check("t1_rst_valid", {31'd0, if_valid}, 32'd0);
        step(0, 0, '0, 1, 0);
        check("t1_req_rise", {31'd0, imem_req}, 32'd1);
        check("t1_addr0", imem_addr, 32'h0);
        for (int k = 0; k < 3; k++) begin
            repeat (2) step(0, 0, '0, 1, 0);
            check("t1_valid", {31'd0, if_valid}, 32'd1);
            check("t1_pc", if_pc, 32'(k) * 32'd4);
            step(0, 0, '0, 1, 0);
            check("t1_next_req", {31'd0, imem_req}, 32'd1);
            check("t1_next_addr", imem_addr, 32'(k + 1) * 32'd4);
        end
        step(0, 1, 32'h200, 1, 0);
`ifdef FETCH_PERF_EN
        check("t6_perf_fetched", perf_fetched, 32'd3);
        check("t6_perf_redirects", perf_redirects, 32'd1);
`endif

        // 2: decode stalls while holding if_pc=0x4
        stray_pct = 30;
        repeat (2) step(1, 0, '0, 1, 0);
        for (int i = 0; i < 30 && !(if_valid && if_pc == 32'h4); i++)
            step(0, 0, '0, 1, 0);
        check("t2_hold_pc", if_pc, 32'h4);
        held_instr = if_instr;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, '0, 0, (i == 2));
            check("t2_valid", {31'd0, if_valid}, 32'd1);
            check("t2_pc", if_pc, 32'h4);
            check("t2_instr", if_instr, held_instr);
            check("t2_req", {31'd0, imem_req}, 32'd0);
        end
        step(0, 0, '0, 1, 0);
        check("t2_next_addr", imem_addr, 32'h8);
        stray_pct = 0;

        // 3: redirect while a slow read to 0x8 is in flight
        lat_min = 3; lat_max = 3;
        step(0, 0, '0, 1, 0);
        step(0, 1, 32'h100, 1, 0);
        check("t3_addr_kept", imem_addr, 32'h8);
        for (int i = 0; i < 10 && imem_addr == 32'h8; i++)
            step(0, 0, '0, 1, 0);
        check("t3_new_addr", imem_addr, 32'h100);
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 40 && !if_valid; i++)
            step(0, 0, '0, 1, 0);
        check("t3_first_pc", if_pc, 32'h100);

        // 4: redirect in HOLD with if_ready=1, then ack and redirect together
        step(0, 1, 32'h40, 1, 0);
        check("t4_valid_drop", {31'd0, if_valid}, 32'd0);
        check("t4_addr", imem_addr, 32'h40);
        step(0, 0, '0, 1, 0);
        step(0, 1, 32'h80, 1, 0);
        check("t4_reissue_req", {31'd0, imem_req}, 32'd1);
        check("t4_reissue_addr", imem_addr, 32'h80);
        for (int i = 0; i < 40 && !if_valid; i++)
            step(0, 0, '0, 1, 0);
        check("t4_pc", if_pc, 32'h80);

        // 5: unaligned redirect target and PC wrap
        step(0, 1, 32'h103, 1, 0);
        check("t5_align", imem_addr, 32'h100);
        for (int i = 0; i < 40 && !if_valid; i++)
            step(0, 0, '0, 1, 0);
        step(0, 1, 32'hFFFF_FFFC, 1, 0);
        for (int i = 0; i < 40 && !if_valid; i++)
            step(0, 0, '0, 1, 0);
        check("t5_top_pc", if_pc, 32'hFFFF_FFFC);
        step(0, 0, '0, 1, 0);
        check("t5_wrap_addr", imem_addr, 32'h0);

        // 6: reset while discarding, stray ack in IDLE
        lat_min = 5; lat_max = 5;
        step(0, 0, '0, 1, 0);
        step(0, 1, 32'h300, 1, 0);
        step(1, 0, '0, 1, 0);
        check("t6_req", {31'd0, imem_req}, 32'd0);
        check("t6_addr", imem_addr, RST_PC);
        check("t6_valid", {31'd0, if_valid}, 32'd0);
        check("t6_pc", if_pc, 32'h0);
        check("t6_instr", if_instr, 32'h0);
        step(0, 0, '0, 1, 1);
        check("t6_idle_exit_req", {31'd0, imem_req}, 32'd1);
        check("t6_stray_ignored", {31'd0, if_valid}, 32'd0);
        for (int i = 0; i < 40 && !if_valid; i++)
            step(0, 0, '0, 1, 0);
        check("t6_first_pc", if_pc, 32'h0);

        // Random traffic
        lat_min = 1; lat_max = 4; stray_pct = 20;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(15, 0) == 0) ? 32'hFFFF_FFFF : $urandom;
            step(($urandom_range(199, 0) == 0), ($urandom_range(99, 0) < 10), rpc,
                 ($urandom_range(99, 0) < 70), 0);
        end
        compare_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Fetch-stage controller. It owns the program counter, issues one-at-a-time read requests to instruction memory over a req/ack handshake, and presents each returned instruction to decode with a valid/ready handshake. It also handles branch redirects, including discarding a response that is already in flight. It sits between the core's branch/redirect logic and the instruction memory, replacing free-running PC increment with a stall- and latency-tolerant sequencer.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
redirect_valid  input  1  branch taken / redirect request, single-cycle qualifier
redirect_pc  input  32  redirect target address
imem_req  output  1  read request to instruction memory
imem_addr  output  32  read address; word aligned
imem_ack  input  1  read response valid; data on imem_rdata same cycle
imem_rdata  input  32  instruction data
if_valid  output  1  instruction available to decode
if_pc  output  32  address of the presented instruction
if_instr  output  32  presented instruction
if_ready  input  1  decode accepts the instruction

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, pc_q=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0.
- Reset has priority over all inputs. It may occur mid-request; the memory shares the same reset, and any ack seen in IDLE is ignored.
- Memory protocol:
  - At most one request outstanding.
  - Once imem_req rises, imem_req and imem_addr stay stable until the cycle imem_ack=1.
  - imem_ack may arrive 1..N cycles after imem_req rises (N unbounded).
  - imem_ack in IDLE or HOLD is ignored.
- State machine, all outputs registered:
  - IDLE: the cycle after reset deasserts, go to FETCH. imem_req goes high with imem_addr=pc_q.
  - FETCH: imem_req=1, imem_addr=pc_q.
    - ack and no redirect: capture if_instr<=imem_rdata, if_pc<=pc_q, if_valid<=1; pc_q<=pc_q+4; imem_req<=0; go HOLD.
    - ack and redirect same cycle: drop data; pc_q<=redirect_pc; stay FETCH. imem_req stays 1 with the new address from the next cycle.
    - no ack and redirect: pc_q<=redirect_pc; go DISCARD. imem_req and imem_addr keep the old address.
  - DISCARD: imem_req=1 with the old address. A further redirect overwrites pc_q (latest wins). On ack: drop data; go FETCH with imem_addr=pc_q.
  - HOLD: imem_req=0; if_valid, if_pc and if_instr are held stable.
    - redirect (any if_ready): if_valid<=0, pc_q<=redirect_pc, go FETCH. The held instruction is dropped even if if_ready=1.
    - if_ready and no redirect: if_valid<=0, go FETCH with imem_addr=pc_q.
- Timing: with 1-cycle memory latency and if_ready=1, the sustained rate is 1 instruction per 3 cycles (FETCH, ack/capture, HOLD). The first instruction appears 2 cycles after IDLE exits.
- Arithmetic:
  - redirect_pc[1:0] is forced to 00 on capture.
  - pc_q+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- if_valid never deasserts without acceptance, except on redirect or reset.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs perf_fetched[31:0] and perf_redirects[31:0], both reset to 0 and wrapping at 2^32.
  - perf_fetched increments on HOLD acceptance (if_ready=1 and redirect_valid=0).
  - perf_redirects increments on every cycle with redirect_valid=1 outside IDLE.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset 3 cycles, memory ack latency 1, if_ready=1 -> imem_req high on the 2nd cycle after reset drops with addr 0x0. Outputs if_pc sequence 0x0, 0x4, 0x8 with matching imem_rdata; no output gaps other than the 3-cycle cadence.
2. if_ready=0 for 5 cycles while HOLD with if_pc=0x4 -> if_valid, if_pc and if_instr constant, imem_req=0. Raise if_ready -> next request addr 0x8.
3. Ack latency 3, redirect_valid with redirect_pc=0x100 one cycle after a request to 0x8 -> imem_addr stays 0x8 until ack, data dropped, next request addr 0x100, first presented if_pc=0x100.
4. In HOLD with if_ready=1 and redirect_valid with redirect_pc=0x40 same cycle -> instruction not counted as accepted, if_valid=0 next cycle, next request addr 0x40. Also: ack and redirect in the same FETCH cycle -> data dropped, request reissued at target.
5. redirect_pc=0x103 -> request addr 0x100. redirect to 0xFFFF_FFFC, accept it -> next request addr 0x0000_0000.
6. reset asserted in DISCARD with a later stray ack -> all outputs at reset values, stray ack ignored in IDLE. With FETCH_PERF_EN, after scenario 1 (3 accepted) plus one redirect -> perf_fetched=3, perf_redirects=1.
